uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Memory-mapped 8N1 UART receiver, the receive-side counterpart of the existing uart_tx peripheral.
- Decoded at uart_rx_base_addr 0x1000004 with mask 0x3.
- Oversamples the asynchronous rx pin with a bit-period counter and assembles bytes LSB first.
- Buffers received bytes in a small FIFO that the CPU drains through the standard valid/ready memory port.

Parameters:
- CLK_DIVIDER_BIT, 217, clock cycles per bit (cpu_freq / baudrate = 25 MHz / 115200).
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two and at least 2.

Ports:
- reset  input  1  asynchronous, active-low reset
- clock  input  1  CPU clock (25 MHz)
- uart_valid  input  1  request strobe
- uart_instr  input  1  instruction fetch flag (ignored)
- uart_addr  input  32  byte address (ignored; decode done upstream)
- uart_wdata  input  32  write data (ignored)
- uart_wstrb  input  4  write strobes; zero means read
- uart_rdata  output  32  read data
- uart_ready  output  1  response strobe
- rx  input  1  serial line, idle high, asynchronous

Behaviour:
- Reset values:
  - uart_rdata = 0, uart_ready = 0.
  - FSM in IDLE; FIFO empty; sticky flags cleared.
  - Both synchronizer flops = 1, so a low rx during reset does not fake a start bit.
- Synchronizer: rx passes through 2 flops. rx_s denotes the second flop. All sampling uses rx_s.
- FSM, counter cnt of width $clog2(CLK_DIVIDER_BIT):
  - IDLE: when rx_s = 0, clear cnt and go to START.
  - START: count to CLK_DIVIDER_BIT/2 - 1 (mid start bit), then sample rx_s.
    - rx_s = 0: clear cnt and bit index, go to DATA.
    - rx_s = 1: glitch; return to IDLE.
  - DATA: count to CLK_DIVIDER_BIT - 1, sample rx_s into shift[7] and shift right by one. After the 8th sample, go to STOP.
  - STOP: count to CLK_DIVIDER_BIT - 1, sample the stop bit, push the byte (see feature below), return to IDLE.
- Re-arm: IDLE re-arms immediately after the stop sample, so back-to-back frames are accepted with no idle gap.
- FIFO:
  - Circular buffer with pointers one bit wider than log2(FIFO_DEPTH); full and empty come from the pointer MSB compare.
  - Push while full drops the new byte and sets sticky overrun.
  - Push and pop in the same cycle while full: both take effect, and no overrun is flagged.
  - Push and pop in the same cycle while empty: the pop returns empty status and the pushed byte is retained.
- Bus response: single-cycle latency. uart_ready = 1 in the cycle after uart_valid = 1, for one cycle.
  - Read (wstrb = 0): uart_rdata[7:0] = head byte, bit 8 = FIFO non-empty, bit 9 = frame error, bit 10 = overrun, rest 0.
    - If non-empty, the head entry is popped.
    - Bits 9 and 10 clear on that read, unless set again in the same cycle (set wins).
    - When the FIFO is empty, bits [7:0] = 0.
  - Write: ignored; uart_ready is still returned and uart_rdata = 0.
  - uart_ready deasserts when uart_valid is not pulsed, so the CPU issues one request per transaction.
- Reset mid-frame: the FSM returns to IDLE and any partial byte is discarded. The next falling edge after reset release starts a new frame.

Optional Feature:
- Macro: UART_RX_FERR_EN.
- Defined: the stop-bit sample must be 1.
  - Stop bit = 0: the byte is not pushed and the sticky frame-error flag (rdata bit 9) is set.
  - The FSM still returns to IDLE; the line staying low then re-triggers START, which the glitch filter handles.
- Undefined: the stop bit is not checked, every byte is pushed, and rdata bit 9 reads 0.

Decomposition:
- Shared package: the rx FSM state enum typedef (IDLE/START/DATA/STOP) and the status bit index localparams (8, 9, 10).
- CLK_DIVIDER_BIT default derives from the configure package's clk_divider_bit.
- One natural sub-module, uart_rx_fifo: a parameterised byte FIFO with push/pop/full/empty. It is reusable by a buffered uart_tx.

Test Plan:
- Send 0xA5 at CLK_DIVIDER_BIT = 16, then a read → uart_ready one cycle after valid, rdata = 0x1A5; a second read → rdata = 0x000.
- Send 5 bytes 0x01..0x05 with no reads (FIFO_DEPTH = 4), then 5 reads → 0x501, 0x102, 0x103, 0x104, 0x000. The overrun flag appears on the first read only.
- rx low pulse of 4 cycles (shorter than half a bit) → no byte pushed; a read returns 0x000.
- With UART_RX_FERR_EN, send 0x3C with stop bit = 0 → a read returns 0x200; next, a valid frame 0x3C → a read returns 0x13C.
- Assert reset during DATA bit 4 of a frame, release, send 0x7E → a read returns 0x17E only, with no partial byte.
- Write with wstrb = 0xF while 1 byte is buffered → uart_ready pulses and rdata = 0; a following read still returns 0x1xx.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the memory-mapped UART receiver.
// Optional stop-bit checking is enabled with the UART_RX_FERR_EN macro.
package uart_rx_pkg;

    // Bit period in CPU clocks: 25 MHz / 115200 baud
    localparam int unsigned clk_divider_bit = 25_000_000 / 115_200;

    // Status bit positions in the read data word
    localparam int unsigned ST_NONEMPTY_BIT = 8;
    localparam int unsigned ST_FERR_BIT     = 9;
    localparam int unsigned ST_OVR_BIT      = 10;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Parameterised circular byte FIFO with push/pop, full/empty and drop
// indication. A push and a pop in the same cycle while full both take effect.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_c,
    output logic             o_full_c,
    output logic             o_empty_c,
    output logic             o_drop_c
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;
    logic             w_wr;

    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop     = i_pop & ~o_empty_c;
    assign w_wr      = i_push & (~o_full_c | w_pop);
    assign o_drop_c  = i_push & o_full_c & ~w_pop;
    assign o_head_c  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // Storage array, no reset needed since empty status masks stale data
    always_ff @(posedge clock) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver with a small receive FIFO.
// Define UART_RX_FERR_EN to drop bytes with a bad stop bit and flag a frame error.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLK_DIVIDER_BIT = clk_divider_bit,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        reset,
    input  logic        clock,
    input  logic        uart_valid,
    input  logic        uart_instr,
    input  logic [31:0] uart_addr,
    input  logic [31:0] uart_wdata,
    input  logic [3:0]  uart_wstrb,
    output logic [31:0] uart_rdata,
    output logic        uart_ready,
    input  logic        rx
);

    localparam int unsigned   CW       = $clog2(CLK_DIVIDER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIVIDER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLK_DIVIDER_BIT - 1);

    logic          r_rx_meta;
    logic          r_rx_s;
    rx_state_e     r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_push;
    logic          r_ferr_set;
    logic          r_ferr;
    logic          r_ovr;

    logic          w_read;
    logic [7:0]    w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_drop;
    logic [31:0]   w_status;
    logic          w_unused;

    assign w_unused = &{1'b0, uart_instr, uart_addr, uart_wdata, w_full};
    assign w_read   = uart_valid & ~(|uart_wstrb);

    // Two-flop synchronizer, reset high so a low line cannot fake a start bit
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receive FSM: mid-bit sampling, LSB-first assembly, one-cycle push strobe
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= RX_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
        end else begin
            r_push     <= 1'b0;
            r_ferr_set <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (!r_rx_s) begin
                        r_cnt   <= '0;
                        r_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_cnt == CNT_HALF) begin
                        if (!r_rx_s) begin
                            r_cnt     <= '0;
                            r_bit_idx <= '0;
                            r_state   <= RX_DATA;
                        end else begin
                            r_state <= RX_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (r_cnt == CNT_FULL) begin
                        r_cnt   <= '0;
                        r_state <= RX_IDLE;
`ifdef UART_RX_FERR_EN
                        if (r_rx_s) begin
                            r_push <= 1'b1;
                        end else begin
                            r_ferr_set <= 1'b1;
                        end
`else
                        r_push <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (r_push),
        .i_data    (r_shift),
        .i_pop     (w_read),
        .o_head_c  (w_head),
        .o_full_c  (w_full),
        .o_empty_c (w_empty),
        .o_drop_c  (w_drop)
    );

    // Status word presented on a read
    always_comb begin
        w_status                  = '0;
        w_status[7:0]             = w_empty ? 8'h00 : w_head;
        w_status[ST_NONEMPTY_BIT] = ~w_empty;
        w_status[ST_FERR_BIT]     = r_ferr;
        w_status[ST_OVR_BIT]      = r_ovr;
    end

    // Sticky flags (set wins over read-clear) and single-cycle bus response
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
            uart_ready <= 1'b0;
            uart_rdata <= '0;
        end else begin
            r_ferr     <= r_ferr_set | (r_ferr & ~w_read);
            r_ovr      <= w_drop | (r_ovr & ~w_read);
            uart_ready <= uart_valid;
            uart_rdata <= w_read ? w_status : 32'h0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 16-clock bit period and a 4-entry FIFO.
module tb_uart_rx;

    localparam int unsigned CDB = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        uart_valid = 1'b0;
    logic        uart_instr = 1'b0;
    logic [31:0] uart_addr  = 32'h0100_0004;
    logic [31:0] uart_wdata = 32'h0;
    logic [3:0]  uart_wstrb = 4'h0;
    logic [31:0] uart_rdata;
    logic        uart_ready;
    logic        rx = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx #(
        .CLK_DIVIDER_BIT (CDB),
        .FIFO_DEPTH      (4)
    ) dut (
        .reset      (reset),
        .clock      (clock),
        .uart_valid (uart_valid),
        .uart_instr (uart_instr),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_wstrb (uart_wstrb),
        .uart_rdata (uart_rdata),
        .uart_ready (uart_ready),
        .rx         (rx)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0]  data;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
    endtask

    // Hold rx at b for exactly one bit period
    task automatic drive_bit(input logic b);
        @(posedge clock);
        #1 rx = b;
        repeat (CDB - 1) @(posedge clock);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    // One bus access; checks the ready pulse shape and the returned data
    task automatic bus(input string name, input logic [3:0] strb, input logic [31:0] exp);
        logic early, rdy, late;
        logic [31:0] data;
        @(posedge clock);
        #1 uart_valid = 1'b1;
        uart_wstrb = strb;
        @(negedge clock);
        early = uart_ready;
        @(posedge clock);
        #1 uart_valid = 1'b0;
        uart_wstrb = 4'h0;
        @(negedge clock);
        rdy  = uart_ready;
        data = uart_rdata;
        @(negedge clock);
        late = uart_ready;
        check({name, "_ready"}, {29'b0, early, rdy, late}, 32'b010);
        check({name, "_rdata"}, data, exp);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 32'h1A5};
        vecs[1] = '{8'h00, 32'h100};
        vecs[2] = '{8'hFF, 32'h1FF};
        vecs[3] = '{8'h81, 32'h181};
        vecs[4] = '{8'h3C, 32'h13C};

        // Reset state
        idle(3);
        @(negedge clock);
        check("reset_ready", {31'b0, uart_ready}, 32'h0);
        check("reset_rdata", uart_rdata, 32'h0);
        #1 reset = 1'b1;
        idle(3);
        bus("empty_read", 4'h0, 32'h000);

        // Single frames, each followed by a read and an empty read
        for (int i = 0; i < 5; i++) begin
            send_byte(vecs[i].data, 1'b1);
            idle(4);
            bus($sformatf("vec%0d", i), 4'h0, vecs[i].exp_rdata);
            bus($sformatf("vec%0d_drained", i), 4'h0, 32'h000);
        end

        // Five back-to-back frames into a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        idle(4);
        bus("ovr_rd0", 4'h0, 32'h501);
        bus("ovr_rd1", 4'h0, 32'h102);
        bus("ovr_rd2", 4'h0, 32'h103);
        bus("ovr_rd3", 4'h0, 32'h104);
        bus("ovr_rd4", 4'h0, 32'h000);

        // Glitch shorter than half a bit
        @(posedge clock);
        #1 rx = 1'b0;
        idle(4);
        #1 rx = 1'b1;
        idle(3 * CDB);
        bus("glitch", 4'h0, 32'h000);

        // Bad stop bit
        send_byte(8'h3C, 1'b0);
        drive_bit(1'b1);
        idle(2 * CDB);
`ifdef UART_RX_FERR_EN
        bus("ferr", 4'h0, 32'h200);
        send_byte(8'h3C, 1'b1);
        idle(4);
        bus("ferr_good", 4'h0, 32'h13C);
`else
        bus("nostop_check", 4'h0, 32'h13C);
        bus("nostop_drained", 4'h0, 32'h000);
`endif

        // Reset during data bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        @(posedge clock);
        #1 rx = 1'b0;
        idle(5);
        #1 reset = 1'b0;
        rx = 1'b1;
        idle(3);
        @(negedge clock);
        check("midreset_rdata", uart_rdata, 32'h0);
        #1 reset = 1'b1;
        idle(CDB);
        send_byte(8'h7E, 1'b1);
        idle(4);
        bus("after_reset", 4'h0, 32'h17E);
        bus("after_reset_drained", 4'h0, 32'h000);

        // Write is acknowledged with zero data and leaves the FIFO intact
        send_byte(8'h5A, 1'b1);
        idle(4);
        bus("write", 4'hF, 32'h000);
        bus("after_write", 4'h0, 32'h15A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
